// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory handshake and the decode-side signals of
// the fetch stage. The fetch unit connects through the master modport; the
// memory/decode environment connects through the slave modport.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        fault;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output Instr,
        output PC,
        output PCPlus4,
        output instr_valid,
        input  instr_ready,
        input  PCSrc,
        input  PCTarget,
        output fault
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  Instr,
        input  PC,
        input  PCPlus4,
        input  instr_valid,
        output instr_ready,
        output PCSrc,
        output PCTarget,
        input  fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the program counter, fetches one 32-bit word
// per request/acknowledge handshake and holds it for decode until the
// downstream stage accepts it. A misaligned branch/jump target parks the unit
// in HALT with a sticky fault until reset. RESET_PC must be word-aligned.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master fetch_if
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        fault_q;

    logic [31:0] pcPlus4;
    logic [31:0] pc_d;
    logic        accept;
    logic        ackTaken;
    logic        targetMisaligned;

    // Next-PC selection and handshake qualifiers; the target is only looked at
    // in the accept cycle, and an ack only counts while a request is out.
    always_comb begin
        pcPlus4          = pc_q + 32'd4;
        pc_d             = fetch_if.PCSrc ? fetch_if.PCTarget : pcPlus4;
        accept           = (state_q == HOLD) && valid_q && fetch_if.instr_ready;
        ackTaken         = (state_q == FETCH) && req_q && fetch_if.imem_ack;
        targetMisaligned = fetch_if.PCSrc && (fetch_if.PCTarget[1:0] != 2'b00);
    end

    // Fetch FSM with all outputs registered; reset overrides any ack or accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ackTaken) begin
                        instr_q <= fetch_if.imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= HOLD;
                    end else begin
                        req_q   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        if (targetMisaligned) begin
                            req_q   <= 1'b0;
                            fault_q <= 1'b1;
                            state_q <= HALT;
                        end else begin
                            pc_q    <= pc_d;
                            req_q   <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                HALT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign fetch_if.imem_req    = req_q;
    assign fetch_if.imem_addr   = pc_q;
    assign fetch_if.Instr       = instr_q;
    assign fetch_if.PC          = pc_q;
    assign fetch_if.PCPlus4     = pcPlus4;
    assign fetch_if.instr_valid = valid_q;
    assign fetch_if.fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, self-checking bench for instr_fetch_unit. A small memory model
// answers with data = address ^ A5A5A5A5; expected PC/Instr pairs are queued
// when a fetch is acknowledged and compared when the DUT presents them.
module tb_instr_fetch_unit;

    localparam logic [31:0] PATTERN = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } expEntry_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   lastGuard;
    expEntry_t expQ[$];

    instr_fetch_unit_if if0();
    instr_fetch_unit_if if1();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .fetch_if (if0)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .fetch_if (if1)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a step never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic ready,
                                 input logic src, input logic [31:0] target);
        if0.imem_ack    = ack;
        if0.imem_rdata  = rdata;
        if0.instr_ready = ready;
        if0.PCSrc       = src;
        if0.PCTarget    = target;
    endtask

    // Waits (bounded) for a request, checks the address is held for the
    // given number of wait cycles, acks it and compares the held instruction.
    task automatic serveFetch(input logic [31:0] expAddr, input int latency);
        int        guard;
        expEntry_t entry;
        guard = 0;
        while (if0.imem_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        lastGuard = guard;
        checkOutput("reqSeen", if0.imem_req, 1);
        for (int c = 0; c < latency; c++) begin
            checkOutput("addrStable", if0.imem_addr, expAddr);
            checkOutput("noEarlyValid", if0.instr_valid, 0);
            @(negedge clk);
        end
        checkOutput("addrAtAck", if0.imem_addr, expAddr);
        expQ.push_back('{addr: expAddr, data: expAddr ^ PATTERN});
        applyStimulus(1'b1, expAddr ^ PATTERN, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        checkOutput("validAfterAck", if0.instr_valid, 1);
        checkOutput("reqDropped", if0.imem_req, 0);
        if (if0.instr_valid === 1'b1 && expQ.size() > 0) begin
            entry = expQ.pop_front();
            checkOutput("PC", if0.PC, entry.addr);
            checkOutput("Instr", if0.Instr, entry.data);
            checkOutput("PCPlus4", if0.PCPlus4, entry.addr + 32'd4);
        end
    endtask

    // Accepts the held instruction for one cycle and checks the next fetch.
    task automatic acceptNow(input logic src, input logic [31:0] target, input logic [31:0] expNext);
        applyStimulus(1'b0, 32'h0, 1'b1, src, target);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("validDropped", if0.instr_valid, 0);
        checkOutput("reqAfterAccept", if0.imem_req, 1);
        checkOutput("nextAddr", if0.imem_addr, expNext);
    endtask

    // Directed sequence: reset, streaming, wait states, branch, stall,
    // fault, wrap-around and reset-versus-ack priority.
    initial begin
        errors = 0;
        checks = 0;
        lastGuard = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        if1.imem_ack    = 1'b0;
        if1.imem_rdata  = 32'h0;
        if1.instr_ready = 1'b0;
        if1.PCSrc       = 1'b0;
        if1.PCTarget    = 32'h0;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rstReq", if0.imem_req, 0);
        checkOutput("rstValid", if0.instr_valid, 0);
        checkOutput("rstInstr", if0.Instr, NOP);
        checkOutput("rstPC", if0.PC, 32'h0);
        checkOutput("rstPCPlus4", if0.PCPlus4, 32'h4);
        checkOutput("rstFault", if0.fault, 0);
        checkOutput("rstPC1", if1.PC, 32'hFFFF_FFFC);
        checkOutput("rstPCPlus4Wrap", if1.PCPlus4, 32'h0);

        rst = 1'b0;
        @(negedge clk);
        checkOutput("firstReq", if0.imem_req, 1);
        checkOutput("firstAddr", if0.imem_addr, 32'h0);

        $display("[TB] wrap-around at top of address space");
        checkOutput("wrapReq", if1.imem_req, 1);
        checkOutput("wrapAddr", if1.imem_addr, 32'hFFFF_FFFC);
        if1.imem_ack   = 1'b1;
        if1.imem_rdata = 32'hFFFF_FFFC ^ PATTERN;
        @(negedge clk);
        if1.imem_ack = 1'b0;
        checkOutput("wrapValid", if1.instr_valid, 1);
        checkOutput("wrapInstr", if1.Instr, 32'hFFFF_FFFC ^ PATTERN);
        if1.instr_ready = 1'b1;
        @(negedge clk);
        if1.instr_ready = 1'b0;
        checkOutput("wrapNextReq", if1.imem_req, 1);
        checkOutput("wrapNextAddr", if1.imem_addr, 32'h0);

        $display("[TB] zero-wait sequential stream");
        for (int i = 0; i < 4; i++) begin
            serveFetch(32'(i * 4), 0);
            checkOutput("noStall", 32'(lastGuard), 32'h0);
            acceptNow(1'b0, 32'h0, 32'(i * 4 + 4));
        end

        $display("[TB] three wait cycles then taken branch");
        serveFetch(32'h10, 3);
        acceptNow(1'b1, 32'h40, 32'h40);
        serveFetch(32'h40, 1);
        acceptNow(1'b0, 32'h0, 32'h44);

        $display("[TB] downstream stall with toggling inputs");
        serveFetch(32'h44, 0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(~c[0], 32'h1111_0000 + 32'(c), 1'b0, c[0], 32'h80);
            @(negedge clk);
            checkOutput("stallPC", if0.PC, 32'h44);
            checkOutput("stallInstr", if0.Instr, 32'h44 ^ PATTERN);
            checkOutput("stallReq", if0.imem_req, 0);
            checkOutput("stallValid", if0.instr_valid, 1);
        end
        acceptNow(1'b1, 32'h100, 32'h100);

        $display("[TB] misaligned target fault");
        serveFetch(32'h100, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h22);
        @(negedge clk);
        checkOutput("faultSet", if0.fault, 1);
        checkOutput("faultPC", if0.PC, 32'h100);
        checkOutput("faultReq", if0.imem_req, 0);
        checkOutput("faultValid", if0.instr_valid, 0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'h40);
            @(negedge clk);
            checkOutput("haltFault", if0.fault, 1);
            checkOutput("haltReq", if0.imem_req, 0);
            checkOutput("haltValid", if0.instr_valid, 0);
            checkOutput("haltPC", if0.PC, 32'h100);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("recoverPC", if0.PC, 32'h0);
        checkOutput("recoverFault", if0.fault, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("recoverReq", if0.imem_req, 1);

        $display("[TB] reset wins over simultaneous ack");
        rst = 1'b1;
        applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("rstAckValid", if0.instr_valid, 0);
        checkOutput("rstAckInstr", if0.Instr, NOP);
        checkOutput("rstAckReq", if0.imem_req, 0);
        checkOutput("rstAckPC", if0.PC, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        serveFetch(32'h0, 0);
        acceptNow(1'b0, 32'h0, 32'h4);

        checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that owns the program counter, fetches 32-bit instruction words from instruction memory over a request/acknowledge handshake, and presents the held instruction to the decode logic: control unit, register file and immediate sign-extension. It sits directly upstream of immediate generation: its `Instr` output drives the sign-extension input. It consumes the branch/jump target computed downstream from `PC` plus the extended immediate.

## Interface
- `RESET_PC`, 32'h00000000, PC value loaded on reset; must be word-aligned.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `imem_req`  output  1  fetch request to instruction memory.
- `imem_addr`  output  32  fetch byte address; equals `PC`.
- `imem_ack`  input  1  memory returns data this cycle; honoured only while `imem_req`=1.
- `imem_rdata`  input  32  instruction word; valid only in the `imem_ack` cycle.
- `Instr`  output  32  held instruction word for decode/sign extension.
- `PC`  output  32  address of `Instr`.
- `PCPlus4`  output  32  `PC` + 4, modulo 2^32.
- `instr_valid`  output  1  `Instr`/`PC` hold a fetched instruction.
- `instr_ready`  input  1  downstream completes the instruction this cycle.
- `PCSrc`  input  1  1 = take `PCTarget`, 0 = sequential; sampled only on accept.
- `PCTarget`  input  32  branch/jump target.
- `fault`  output  1  sticky misaligned-target fault.

## Operation
- States: FETCH, HOLD, HALT.
- Reset values: state FETCH, `PC`=`RESET_PC`, `Instr`=32'h00000013 (NOP), `instr_valid`=0, `imem_req`=0, `fault`=0.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`PC`, held stable until ack.
  - On `imem_ack`: register `imem_rdata` into `Instr`; go to HOLD.
- HOLD:
  - `instr_valid`=1, `imem_req`=0; `Instr`, `PC` and `PCPlus4` are stable.
  - Accept = `instr_valid` and `instr_ready`.
  - On accept: next PC = `PCSrc` ? `PCTarget` : `PCPlus4`.
  - If `PCSrc`=1 and `PCTarget[1:0]`≠0: go to HALT, set `fault`=1, leave `PC` unchanged.
  - Otherwise: load the next PC and go to FETCH.
- HALT: `imem_req`=0, `instr_valid`=0, `fault`=1; only `rst` exits.
- `Instr` holds its last value outside HOLD; decode must qualify it with `instr_valid`.
- PC arithmetic is 32-bit unsigned with wrap: 32'hFFFFFFFC + 4 = 32'h00000000. The sequential path never faults.
- `imem_ack` is ignored outside FETCH.
- `PCSrc`/`PCTarget` are ignored outside the accept cycle.

## Timing
- `rst`=1 takes priority over every other event in that cycle, including `imem_ack` or accept.
- `imem_req` rises in the first cycle after `rst` deasserts.
- `imem_ack` in cycle n → `instr_valid`=1 and new `Instr` in cycle n+1; `imem_req`=0 from n+1.
- Accept in cycle m → `imem_req`=1 with the new `imem_addr` in cycle m+1; `instr_valid`=0 in m+1.
- Zero-wait memory (ack in the first request cycle) gives a peak throughput of one instruction per 2 cycles.
- Each extra memory wait cycle adds one cycle.
- Instruction memory must be reset by the same `rst`. An ack for a pre-reset request must not arrive after reset.
- `fault` rises in the cycle after the faulting accept.

## Test plan
- Reset, then memory acks every request in the same cycle with data = address ^ 32'hA5A5A5A5, `instr_ready`=1, `PCSrc`=0 → fetch addresses 0,4,8,12; `instr_valid` pulses every 2nd cycle; each `Instr` matches its `PC`.
- Memory acks 3 cycles after the request → `imem_addr` stays stable for 3 cycles; `Instr` appears exactly 1 cycle after ack; no duplicate or missed fetch.
- At `PC`=32'h10, accept with `PCSrc`=1, `PCTarget`=32'h40 → next `imem_addr`=32'h40; then `PCSrc`=0 → 32'h44.
- Hold `instr_ready`=0 for 5 cycles while toggling `imem_ack` and `PCSrc` → `Instr`/`PC` unchanged and no request issued; the accept on cycle 6 uses the `PCSrc` value of that cycle.
- `PCTarget`=32'h22 with `PCSrc`=1 on accept → `fault`=1 next cycle; `PC` stays at the old value; `imem_req` and `instr_valid` stay 0 until `rst`; `rst` restores `PC`=`RESET_PC`, `fault`=0.
- `RESET_PC`=32'hFFFFFFFC, sequential accept → next `imem_addr`=32'h00000000.
- `rst` asserted in the same cycle as `imem_ack` → data discarded, reset values hold.
